// File: rtl/updown_count32_if.sv
// Counter bench interface: driver-side controls and the registered count/status returned by the DUT.
interface updown_count32_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_out;
  logic             carry;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output load, mode, data,
    input  data_out, carry, borrow, ovf, zero
  );

  modport slave (
    input  load, mode, data,
    output data_out, carry, borrow, ovf, zero
  );
endinterface

// File: rtl/updown_count32.sv
// Loadable up/down counter with registered carry/borrow/sticky-overflow/zero flags.
// Wraps or saturates at the boundaries depending on SAT; every output is a flop.
module updown_count32 #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               SAT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  updown_count32_if.slave   bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             at_max, at_min;

  assign at_max = &cnt_q;
  assign at_min = (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    ovf_d    = ovf_q;
    if (bus.load) begin
      cnt_d = bus.data;
      ovf_d = 1'b0;
    end else if (bus.mode) begin
      if (!at_max) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d   = SAT ? cnt_q : '0;
        carry_d = 1'b1;
      end
    end else begin
      if (!at_min) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d    = SAT ? cnt_q : '1;
        borrow_d = 1'b1;
      end
    end
    if (carry_d || borrow_d) begin
      ovf_d = 1'b1;
    end
    // Derived from next state so the flag lands in the same cycle as the count.
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= RST_VAL;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= (RST_VAL == '0);
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.data_out = cnt_q;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.ovf      = ovf_q;
  assign bus.zero     = zero_q;

  // Unknown controls out of reset leave the next state undefined.
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown({bus.load, bus.mode}))
    else $error("updown_count32: X on load/mode");

endmodule

// File: tb/tb_updown_count32.sv
// Directed bench: wrapping counter driven from a vector table, saturating counter and reset by hand.
module tb_updown_count32;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  updown_count32_if #(.WIDTH(32)) wif ();
  updown_count32_if #(.WIDTH(32)) sif ();

  updown_count32 #(.WIDTH(32), .RST_VAL(32'h0), .SAT(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (wif.slave)
  );

  updown_count32 #(.WIDTH(32), .RST_VAL(32'h0), .SAT(1'b1)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        md;
    logic [31:0] din;
    logic [31:0] q;
    logic        c;
    logic        b;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_w(input string tag, input logic [31:0] q, input logic c, input logic b,
                         input logic o, input logic z);
    check({tag, ".data_out"}, wif.data_out, q);
    check({tag, ".carry"}, {31'b0, wif.carry}, {31'b0, c});
    check({tag, ".borrow"}, {31'b0, wif.borrow}, {31'b0, b});
    check({tag, ".ovf"}, {31'b0, wif.ovf}, {31'b0, o});
    check({tag, ".zero"}, {31'b0, wif.zero}, {31'b0, z});
  endtask

  task automatic check_s(input string tag, input logic [31:0] q, input logic c, input logic b,
                         input logic o, input logic z);
    check({tag, ".data_out"}, sif.data_out, q);
    check({tag, ".carry"}, {31'b0, sif.carry}, {31'b0, c});
    check({tag, ".borrow"}, {31'b0, sif.borrow}, {31'b0, b});
    check({tag, ".ovf"}, {31'b0, sif.ovf}, {31'b0, o});
    check({tag, ".zero"}, {31'b0, sif.zero}, {31'b0, z});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst      = 1'b0;
    wif.load = 1'b0;
    wif.mode = 1'b1;
    wif.data = 32'h0;
    sif.load = 1'b1;
    sif.mode = 1'b1;
    sif.data = 32'h0;

    // Power-on reset
    step();
    step();
    check_w("por", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_s("por_sat", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;

    // Count a little, then reset mid-count asynchronously
    step(); check_w("cnt1", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); check_w("cnt2", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); check_w("cnt3", 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_w("rst_async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    wif.load = 1'b1;
    wif.data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check_w($sformatf("rst_hold%0d", i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    rst      = 1'b1;
    wif.load = 1'b0;
    wif.mode = 1'b1;
    step(); check_w("rst_first", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrapping counter vector table: ld, md, din, q, c, b, o, z
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h1,         32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'd100,       32'd100,       1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'd101,       1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         32'd100,       1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,         32'd101,       1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         32'd100,       1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h5,         32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      wif.load = vecs[i].ld;
      wif.mode = vecs[i].md;
      wif.data = vecs[i].din;
      step();
      check_w($sformatf("vec%0d", i), vecs[i].q, vecs[i].c, vecs[i].b, vecs[i].o, vecs[i].z);
    end

    // Saturating counter at the top
    sif.load = 1'b1; sif.data = 32'hFFFF_FFFE;
    step(); check_s("sat_ld", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    sif.load = 1'b0; sif.mode = 1'b1;
    step(); check_s("sat_up0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); check_s("sat_up1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); check_s("sat_up2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    sif.mode = 1'b0;
    step(); check_s("sat_dn", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);

    // Saturating counter at zero
    sif.load = 1'b1; sif.data = 32'h1;
    step(); check_s("satz_ld", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    sif.load = 1'b0;
    step(); check_s("satz_dn0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); check_s("satz_dn1", 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); check_s("satz_dn2", 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    sif.mode = 1'b1;
    step(); check_s("satz_up", 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
